// File: rtl/itr_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// status-word bit positions and winner-id width.
package itr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } itr_state_e;

    // The "any eligible" flag sits in the status word's top bit.
    function automatic int unsigned stat_msb(input int unsigned nubits);
        return nubits - 1;
    endfunction

    // Winner ids are encoded as index+1 so that 0 can mean "none".
    function automatic int unsigned id_width(input int unsigned nsrc);
        return $clog2(nsrc + 1);
    endfunction

endpackage

// File: rtl/itr_sync_edge.sv
// Per-source synchronizer chain followed by a rising-edge detector on the
// synchronized bit; rise_o is a single-cycle pulse.
module itr_sync_edge
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    output logic rise_o
);

    logic [SYNC-1:0] sync_q, sync_d;
    logic            prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC-2:0], src_i};
        prev_d = sync_q[SYNC-1];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_o = sync_q[SYNC-1] & ~prev_q;

endmodule

// File: rtl/itr_ctrl.sv
// Interrupt controller: latches source edges, applies the mask, picks the
// lowest eligible source and issues one itr pulse per event until acknowledged.
module itr_ctrl
    import itr_ctrl_pkg::*;
#(
    parameter int unsigned NUBITS    = 16,
    parameter int unsigned NSRC      = 4,
    parameter int unsigned NUIOIN    = 2,
    parameter int unsigned NUIOOU    = 2,
    parameter int unsigned MASK_ADDR = 1,
    parameter int unsigned STAT_ADDR = 1,
    parameter int unsigned SYNC      = 2,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src,
    input  logic [NUBITS-1:0]         wr_data,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic                      out_en,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    input  logic                      req_in,
    output logic [NUBITS-1:0]         rd_data,
    output logic                      rd_sel,
    output logic                      itr,
    output logic                      in_svc
);

    localparam int unsigned AOW = $clog2(NUIOOU);
    localparam int unsigned AIW = $clog2(NUIOIN);
    localparam int unsigned IDW = id_width(NSRC);
    localparam int unsigned MSB = stat_msb(NUBITS);
    localparam int unsigned HW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d;
    logic [NSRC-1:0] rise, elig, ack_vec;
    logic [IDW-1:0]  win_id;
    logic            any_elig, mask_wr, rd_ack;
    itr_state_e      state_q, state_d;
    logic [HW-1:0]   cnt_q, cnt_d;
    logic            itr_q, itr_d, in_svc_q, in_svc_d;

    logic unused_wr_data;
    assign unused_wr_data = ^wr_data[NUBITS-1:NSRC];

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        itr_sync_edge #(
            .SYNC(SYNC)
        ) u_sync (
            .clk_i (clk),
            .rst_ni(rst),
            .src_i (src[g]),
            .rise_o(rise[g])
        );
    end

    assign elig     = pend_q & mask_q;
    assign any_elig = |elig;
    assign mask_wr  = out_en && (addr_out == AOW'(MASK_ADDR));
    assign rd_sel   = req_in && (addr_in == AIW'(STAT_ADDR));
    assign rd_ack   = rd_sel && any_elig;

    always_comb begin
        win_id  = '0;
        ack_vec = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) win_id = IDW'(i + 1);
        end
        for (int i = 0; i < NSRC; i++) begin
            ack_vec[i] = rd_ack && (win_id == IDW'(i + 1));
        end
    end

    always_comb begin
        rd_data          = '0;
        rd_data[MSB]     = any_elig;
        rd_data[IDW-1:0] = win_id;
    end

    // A fresh edge arriving with the acknowledge of the same bit must survive.
    assign pend_d = (pend_q & ~ack_vec) | rise;
    assign mask_d = mask_wr ? wr_data[NSRC-1:0] : mask_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_svc_d = in_svc_q;
        itr_d    = (state_q == StFire);
        unique case (state_q)
            StIdle: if (any_elig) state_d = StIdle == StIdle ? StFire : StIdle;
            StFire: begin
                state_d  = StWait;
                in_svc_d = 1'b1;
            end
            StWait: begin
                if (rd_ack) begin
                    in_svc_d = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHold;
                        cnt_d   = HW'(HOLDOFF);
                    end
                end
            end
            StHold: begin
                if (cnt_q <= HW'(1)) state_d = StIdle;
                else                 cnt_d   = cnt_q - HW'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q   <= '0;
            mask_q   <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            itr_q    <= 1'b0;
            in_svc_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            itr_q    <= itr_d;
            in_svc_q <= in_svc_d;
        end
    end

    assign itr    = itr_q;
    assign in_svc = in_svc_q;

endmodule

// File: tb/tb_itr_ctrl.sv
// Self-checking bench for itr_ctrl: vector table of mask/source patterns with a
// scoreboard of expected status reads, plus hand-written boundary sequences.
module tb_itr_ctrl;

    localparam int NUBITS  = 16;
    localparam int NSRC    = 4;
    localparam int SYNC    = 2;
    localparam int HOLDOFF = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NSRC-1:0]   src = '0;
    logic [NUBITS-1:0] wr_data = '0;
    logic              addr_out = 1'b0;
    logic              out_en = 1'b0;
    logic              addr_in = 1'b0;
    logic              req_in = 1'b0;
    logic [NUBITS-1:0] rd_data;
    logic              rd_sel, itr, in_svc;

    always #5 clk = ~clk;

    itr_ctrl #(
        .NUBITS(NUBITS), .NSRC(NSRC), .NUIOIN(2), .NUIOOU(2), .MASK_ADDR(1),
        .STAT_ADDR(1), .SYNC(SYNC), .HOLDOFF(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .src(src), .wr_data(wr_data), .addr_out(addr_out),
        .out_en(out_en), .addr_in(addr_in), .req_in(req_in), .rd_data(rd_data),
        .rd_sel(rd_sel), .itr(itr), .in_svc(in_svc)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [3:0]       mask;
        logic [3:0]       srcv;
        int               n;
        logic [3:0][15:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] m, input logic [3:0] s, input int n,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        vec_t v;
        v.mask = m;
        v.srcv = s;
        v.n    = n;
        v.exp  = {e3, e2, e1, e0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        src = '0; out_en = 1'b0; req_in = 1'b0; addr_in = 1'b0; addr_out = 1'b0;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        exp_q.delete();
    endtask

    task automatic write_mask(input logic [3:0] m);
        out_en = 1'b1; addr_out = 1'b1; wr_data = 16'(m);
        step();
        out_en = 1'b0; addr_out = 1'b0; wr_data = '0;
    endtask

    // Pops the expected status word queued when the stimulus was driven.
    task automatic read_status(input string name);
        logic [15:0] e;
        e = '0;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: read with empty scoreboard", name);
        end else begin
            e = exp_q.pop_front();
        end
        req_in = 1'b1; addr_in = 1'b1;
        #1;
        chk({name, "_sel"}, 32'(rd_sel), 32'd1);
        chk(name, 32'(rd_data), 32'(e));
        step();
        req_in = 1'b0; addr_in = 1'b0;
    endtask

    task automatic wait_itr(input string name, input int max, output int n);
        n = 0;
        while (!itr && n < max) begin
            step();
            n++;
        end
        chk(name, 32'(itr), 32'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            step();
            if (itr) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    logic itr_prev = 1'b0;
    always @(negedge clk) begin
        if (itr_prev) chk("itr_one_cycle", 32'(itr), 32'd0);
        itr_prev = itr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];
    int   n;

    initial begin
        vecs[0] = mk(4'h4, 4'h4, 1, 16'h8003, 16'h0, 16'h0, 16'h0);
        vecs[1] = mk(4'hF, 4'hA, 2, 16'h8002, 16'h8004, 16'h0, 16'h0);
        vecs[2] = mk(4'hF, 4'hF, 4, 16'h8001, 16'h8002, 16'h8003, 16'h8004);
        vecs[3] = mk(4'h5, 4'hF, 2, 16'h8001, 16'h8003, 16'h0, 16'h0);
        vecs[4] = mk(4'h0, 4'h3, 0, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[5] = mk(4'h8, 4'h9, 1, 16'h8004, 16'h0, 16'h0, 16'h0);

        // Reset held with toggling sources and attempted mask writes.
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            src = (i % 2 == 0) ? 4'hF : 4'h0;
            out_en = 1'b1; addr_out = 1'b1; wr_data = 16'hFFFF;
            step();
            chk("rst_itr", 32'(itr), 32'd0);
            chk("rst_in_svc", 32'(in_svc), 32'd0);
            chk("rst_rd_data", 32'(rd_data), 32'd0);
        end
        out_en = 1'b0; addr_out = 1'b0; wr_data = '0; src = '0;
        step();
        rst = 1'b1;
        expect_quiet("rst_release_quiet", 12);
        req_in = 1'b1; addr_in = 1'b0;
        #1 chk("rd_sel_wrong_addr", 32'(rd_sel), 32'd0);
        req_in = 1'b0;
        src = 4'h1; step(); src = '0;
        expect_quiet("rst_mask_zero_quiet", 10);
        exp_q.push_back(16'h0000);
        read_status("rst_mask_zero_read");

        // Table of mask/source patterns; reads drain in priority order.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            write_mask(vecs[v].mask);
            src = vecs[v].srcv;
            for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].exp[k]);
            step();
            src = '0;
            for (int k = 0; k < vecs[v].n; k++) begin
                wait_itr($sformatf("v%0d_itr%0d", v, k), 20, n);
                chk($sformatf("v%0d_lat%0d", v, k), 32'(n),
                    (k == 0) ? 32'(SYNC + 2) : 32'(HOLDOFF + 2));
                chk($sformatf("v%0d_svc%0d", v, k), 32'(in_svc), 32'd1);
                read_status($sformatf("v%0d_rd%0d", v, k));
                chk($sformatf("v%0d_unsvc%0d", v, k), 32'(in_svc), 32'd0);
            end
            expect_quiet($sformatf("v%0d_quiet", v), 15);
            exp_q.push_back(16'h0000);
            read_status($sformatf("v%0d_rd_end", v));
        end

        // Masked event stays pending until unmasked.
        do_reset();
        src = 4'h1; step(); src = '0;
        expect_quiet("masked_quiet", 8);
        exp_q.push_back(16'h0000);
        read_status("masked_rd_none");
        write_mask(4'h1);
        chk("unmask_itr_w0", 32'(itr), 32'd0);
        step();
        chk("unmask_itr_w1", 32'(itr), 32'd0);
        step();
        chk("unmask_itr_w2", 32'(itr), 32'd1);
        exp_q.push_back(16'h8001);
        read_status("unmask_rd");

        // New edge on bit 1 lands in the same cycle as its acknowledge.
        do_reset();
        write_mask(4'h2);
        src = 4'h2; step(); src = '0;
        wait_itr("svc_first_itr", 20, n);
        step();
        src = 4'h2;
        step(); step();
        exp_q.push_back(16'h8002);
        read_status("svc_ack_rd");
        wait_itr("svc_second_itr", 20, n);
        chk("svc_second_gap", 32'(n), 32'(HOLDOFF + 2));
        exp_q.push_back(16'h8002);
        read_status("svc_second_rd");
        expect_quiet("svc_level_quiet", 12);
        src = '0;

        // Mask write and status read in the same cycle: read sees old mask.
        do_reset();
        write_mask(4'hF);
        src = 4'h3; step(); src = '0;
        wait_itr("mw_itr", 20, n);
        out_en = 1'b1; addr_out = 1'b1; wr_data = 16'h0000;
        exp_q.push_back(16'h8001);
        read_status("mw_rd_old_mask");
        out_en = 1'b0; addr_out = 1'b0;
        chk("mw_unsvc", 32'(in_svc), 32'd0);
        expect_quiet("mw_quiet", 12);
        exp_q.push_back(16'h0000);
        read_status("mw_rd_masked");
        write_mask(4'hF);
        wait_itr("mw_itr2", 10, n);
        chk("mw_itr2_lat", 32'(n), 32'd2);
        exp_q.push_back(16'h8002);
        read_status("mw_rd2");

        // Asynchronous reset in WAIT with two events pending.
        do_reset();
        write_mask(4'h6);
        src = 4'h6; step(); src = '0;
        wait_itr("mr_itr", 20, n);
        step();
        chk("mr_svc_before", 32'(in_svc), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mr_svc", 32'(in_svc), 32'd0);
        chk("mr_itr_low", 32'(itr), 32'd0);
        chk("mr_rd_data", 32'(rd_data), 32'd0);
        step();
        rst = 1'b1;
        step();
        exp_q.push_back(16'h0000);
        read_status("mr_rd_after");
        write_mask(4'hF);
        expect_quiet("mr_quiet", 12);
        exp_q.push_back(16'h0000);
        read_status("mr_rd_unmasked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
